// File: rtl/niosii_system_sysid_ext.sv
// System ID slave with build timestamp, snapshot-able uptime counter, scratch and status/control.
// Pipelined Avalon-MM read path: fixed latency of one cycle, qualified by readdatavalid.
module niosii_system_sysid_ext #(
    parameter logic [31:0] ID_VALUE        = 32'h0000_0000,
    parameter logic [31:0] TIMESTAMP_VALUE = 32'd1490297630,
    parameter int          UPTIME_WIDTH    = 64,
    parameter int          ADDR_WIDTH      = 3
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  read,
    input  logic                  write,
    input  logic [31:0]           writedata,
    input  logic [3:0]            byteenable,
    output logic [31:0]           readdata,
    output logic                  readdatavalid
);

    localparam int HI_W = UPTIME_WIDTH - 32;

    localparam logic [ADDR_WIDTH-1:0] A_ID      = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] A_TS      = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] A_UP_LO   = ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0] A_UP_HI   = ADDR_WIDTH'(3);
    localparam logic [ADDR_WIDTH-1:0] A_SCRATCH = ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] A_STATUS  = ADDR_WIDTH'(5);

    logic [UPTIME_WIDTH-1:0] counter_q, counter_d;
    logic [HI_W-1:0]         hi_shadow_q, hi_shadow_d;
    logic [31:0]             scratch_q, scratch_d;
    logic                    wrapped_q, wrapped_d;
    logic                    freeze_q, freeze_d;
    logic [31:0]             readdata_q, readdata_d;
    logic                    rdv_q, rdv_d;

    logic                    rd_req;
    logic                    wrap;
    logic [31:0]             status_word;
    logic [31:0]             rd_mux;

    always_comb begin
        rd_req      = read && !write;
        wrap        = !freeze_q && (counter_q == '1);
        status_word = {16'h0000, 8'(UPTIME_WIDTH), 6'b000000, freeze_q, wrapped_q};

        // The old FREEZE governs this edge; a FREEZE write only affects later edges.
        counter_d   = freeze_q ? counter_q : counter_q + UPTIME_WIDTH'(1);

        // Snapshot uses the pre-edge counter so LO and HI always belong together.
        hi_shadow_d = hi_shadow_q;
        if (rd_req && address == A_UP_LO) begin
            hi_shadow_d = counter_q[UPTIME_WIDTH-1:32];
        end

        scratch_d = scratch_q;
        freeze_d  = freeze_q;
        wrapped_d = wrapped_q;
        if (write && address == A_SCRATCH) begin
            for (int i = 0; i < 4; i++) begin
                if (byteenable[i]) begin
                    scratch_d[8*i +: 8] = writedata[8*i +: 8];
                end
            end
        end
        if (write && address == A_STATUS) begin
            freeze_d = writedata[1];
            if (writedata[0]) begin
                wrapped_d = 1'b0;
            end
        end
        if (wrap) begin
            wrapped_d = 1'b1;
        end

        case (address)
            A_ID:      rd_mux = ID_VALUE;
            A_TS:      rd_mux = TIMESTAMP_VALUE;
            A_UP_LO:   rd_mux = counter_q[31:0];
            A_UP_HI:   rd_mux = 32'(hi_shadow_q);
            A_SCRATCH: rd_mux = scratch_q;
            A_STATUS:  rd_mux = status_word;
            default:   rd_mux = 32'h0000_0000;
        endcase

        rdv_d      = rd_req;
        readdata_d = rd_req ? rd_mux : readdata_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            counter_q   <= '0;
            hi_shadow_q <= '0;
            scratch_q   <= '0;
            wrapped_q   <= 1'b0;
            freeze_q    <= 1'b0;
            readdata_q  <= '0;
            rdv_q       <= 1'b0;
        end else begin
            counter_q   <= counter_d;
            hi_shadow_q <= hi_shadow_d;
            scratch_q   <= scratch_d;
            wrapped_q   <= wrapped_d;
            freeze_q    <= freeze_d;
            readdata_q  <= readdata_d;
            rdv_q       <= rdv_d;
        end
    end

    assign readdata      = readdata_q;
    assign readdatavalid = rdv_q;

endmodule

// File: tb/tb_niosii_system_sysid_ext.sv
// Bench for niosii_system_sysid_ext: a 64-bit and a 33-bit instance share one stimulus stream
// and are scored against a register-level reference model through per-instance expected queues.
module tb_niosii_system_sysid_ext;

    localparam logic [31:0] TS_VALUE = 32'd1490297630;
    localparam logic [31:0] ID1      = 32'hCAFE_0033;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] rd0, rd1;
    logic        rdv0, rdv1;

    always #5 clock = ~clock;

    niosii_system_sysid_ext #(.UPTIME_WIDTH(64)) dut0 (
        .clock(clock), .reset_n(reset_n), .address(address), .read(read), .write(write),
        .writedata(writedata), .byteenable(byteenable), .readdata(rd0), .readdatavalid(rdv0)
    );

    niosii_system_sysid_ext #(.ID_VALUE(ID1), .UPTIME_WIDTH(33)) dut1 (
        .clock(clock), .reset_n(reset_n), .address(address), .read(read), .write(write),
        .writedata(writedata), .byteenable(byteenable), .readdata(rd1), .readdatavalid(rdv1)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] exp_q0[$];
    logic [31:0] exp_q1[$];

    // Reference model: architectural register contents of each instance.
    logic [63:0] m_cnt[2];
    logic [31:0] m_hi[2];
    logic [31:0] m_scr[2];
    logic        m_wrap[2];
    logic        m_frz[2];
    int          m_w[2]  = '{64, 33};
    logic [31:0] m_id[2] = '{32'h0000_0000, ID1};

    function automatic logic [63:0] cnt_max(int k);
        return (m_w[k] == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << m_w[k]) - 64'd1);
    endfunction

    function automatic logic [31:0] exp_read(int k, logic [2:0] a);
        logic [7:0] wv;
        wv = 8'(m_w[k]);
        case (a)
            3'd0:    return m_id[k];
            3'd1:    return TS_VALUE;
            3'd2:    return m_cnt[k][31:0];
            3'd3:    return m_hi[k];
            3'd4:    return m_scr[k];
            3'd5:    return {16'h0000, wv, 6'b000000, m_frz[k], m_wrap[k]};
            default: return 32'h0000_0000;
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_cnt[k]  = 64'd0;
            m_hi[k]   = 32'd0;
            m_scr[k]  = 32'd0;
            m_wrap[k] = 1'b0;
            m_frz[k]  = 1'b0;
        end
        exp_q0.delete();
        exp_q1.delete();
    endtask

    // Advance the model across one rising edge using the inputs currently driven.
    task automatic model_step();
        logic [31:0] e;
        logic        wrap_now;
        logic        frz_new;
        for (int k = 0; k < 2; k++) begin
            if (reset_n && read && !write) begin
                e = exp_read(k, address);
                if (k == 0) exp_q0.push_back(e);
                else        exp_q1.push_back(e);
                if (address == 3'd2) m_hi[k] = 32'(m_cnt[k] >> 32);
            end
            wrap_now = !m_frz[k] && (m_cnt[k] == cnt_max(k));
            frz_new  = m_frz[k];
            if (write && address == 3'd4) begin
                for (int b = 0; b < 4; b++)
                    if (byteenable[b]) m_scr[k][8*b +: 8] = writedata[8*b +: 8];
            end
            if (write && address == 3'd5) begin
                frz_new = writedata[1];
                if (writedata[0]) m_wrap[k] = 1'b0;
            end
            if (wrap_now) m_wrap[k] = 1'b1;
            if (!m_frz[k]) m_cnt[k] = wrap_now ? 64'd0 : m_cnt[k] + 64'd1;
            m_frz[k] = frz_new;
        end
    endtask

    // One bus cycle, entered and left at a falling edge.
    task automatic cycle(input logic rd, input logic wr, input logic [2:0] a,
                         input logic [31:0] wd, input logic [3:0] be);
        read       = rd;
        write      = wr;
        address    = a;
        writedata  = wd;
        byteenable = be;
        model_step();
        @(posedge clock);
        @(negedge clock);
        read  = 1'b0;
        write = 1'b0;
    endtask

    task automatic do_read(input logic [2:0] a);
        cycle(1'b1, 1'b0, a, 32'h0, 4'h0);
    endtask

    task automatic do_write(input logic [2:0] a, input logic [31:0] wd, input logic [3:0] be);
        cycle(1'b0, 1'b1, a, wd, be);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 3'd0, 32'h0, 4'h0);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, " rd0"}, rd0, 32'h0);
        check({name, " rdv0"}, 32'(rdv0), 32'h0);
        check({name, " rd1"}, rd1, 32'h0);
        check({name, " rdv1"}, 32'(rdv1), 32'h0);
    endtask

    // Monitors: each expected response must appear exactly one cycle after its read.
    always @(posedge clock) begin
        #2;
        if (reset_n) begin
            if (rdv0) begin
                if (exp_q0.size() == 0) check("dut0 unexpected readdatavalid", 32'(rdv0), 32'h0);
                else                    check("dut0 readdata", rd0, exp_q0.pop_front());
            end else if (exp_q0.size() != 0) begin
                check("dut0 missing readdatavalid", 32'(rdv0), 32'h1);
                exp_q0.delete();
            end
            if (rdv1) begin
                if (exp_q1.size() == 0) check("dut1 unexpected readdatavalid", 32'(rdv1), 32'h0);
                else                    check("dut1 readdata", rd1, exp_q1.pop_front());
            end else if (exp_q1.size() != 0) begin
                check("dut1 missing readdatavalid", 32'(rdv1), 32'h1);
                exp_q1.delete();
            end
        end
    end

    initial begin
        reset_n    = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
        address    = 3'd0;
        writedata  = 32'h0;
        byteenable = 4'h0;
        model_reset();
        @(negedge clock);
        @(negedge clock);
        check_outputs_zero("in reset");
        reset_n = 1'b1;

        // ID and timestamp back to back.
        do_read(3'd0);
        do_read(3'd1);
        idle(2);

        // Low-word rollover snapshot on the 64-bit instance.
        force dut0.counter_q = 64'h0000_0000_FFFF_FFFF;
        #1 release dut0.counter_q;
        m_cnt[0] = 64'h0000_0000_FFFF_FFFF;
        do_read(3'd2);
        do_read(3'd3);
        do_read(3'd2);
        do_read(3'd3);

        // Byte-lane scratch writes, read back the cycle after.
        do_write(3'd4, 32'hA5A5_A5A5, 4'b1111);
        do_write(3'd4, 32'h1234_5678, 4'b0101);
        do_read(3'd4);
        idle(1);

        // Freeze holds the counter; unfreezing resumes counting.
        do_write(3'd5, 32'h0000_0002, 4'hF);
        do_read(3'd2);
        idle(9);
        do_read(3'd2);
        do_read(3'd5);
        do_write(3'd5, 32'h0000_0000, 4'hF);
        do_read(3'd2);
        idle(7);
        do_read(3'd2);

        // 33-bit wrap, sticky WRAPPED, set beating a simultaneous clear, then clear.
        force dut1.counter_q = 33'h1_FFFF_FFFF;
        #1 release dut1.counter_q;
        m_cnt[1] = 64'h0000_0001_FFFF_FFFF;
        idle(1);
        do_read(3'd5);
        force dut1.counter_q = 33'h1_FFFF_FFFF;
        #1 release dut1.counter_q;
        m_cnt[1] = 64'h0000_0001_FFFF_FFFF;
        do_write(3'd5, 32'h0000_0003, 4'hF);
        do_read(3'd5);
        do_write(3'd5, 32'h0000_0001, 4'hF);
        do_read(3'd5);
        do_write(3'd5, 32'h0000_0000, 4'hF);

        // Writes to read-only words and reserved addresses change nothing.
        for (int a = 0; a < 8; a++) begin
            if (a != 4 && a != 5) do_write(3'(a), $urandom, 4'hF);
        end
        for (int a = 0; a < 8; a++) do_read(3'(a));

        // Randomised traffic, including occasional read+write collisions.
        for (int i = 0; i < 400; i++) begin
            int r;
            logic [2:0] a;
            r = $urandom_range(0, 99);
            a = 3'($urandom_range(0, 7));
            if (r < 50)      do_read(a);
            else if (r < 80) do_write(a, $urandom, 4'($urandom_range(0, 15)));
            else if (r < 85) cycle(1'b1, 1'b1, a, $urandom, 4'($urandom_range(0, 15)));
            else             idle(1);
        end
        idle(1);

        // Reset while a read response is on the bus cancels it at once.
        do_write(3'd4, 32'hDEAD_BEEF, 4'hF);
        do_read(3'd4);
        check("rdv0 before reset", 32'(rdv0), 32'h1);
        reset_n = 1'b0;
        #1;
        check_outputs_zero("async reset");
        @(negedge clock);
        @(negedge clock);
        model_reset();
        reset_n = 1'b1;
        do_read(3'd4);
        do_read(3'd5);
        cycle(1'b1, 1'b1, 3'd4, 32'h0000_1111, 4'hF);
        do_read(3'd4);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
